// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding and default widths for the convolution sequencer
package conv_pkg;
    localparam int TW = 8;
    localparam int KW = 4;
    localparam int CW = 8;
    localparam int SW = 2;
    localparam int AW = 16;
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CALC = 4'b0010,
        RUN  = 4'b0100,
        DONE = 4'b1000
    } state_t;
endpackage

// File: rtl/ofs_divider.sv
// ofs_divider: restoring-free repeated-subtraction divider, one step per enabled cycle
module ofs_divider #(
    parameter int TW = conv_pkg::TW,
    parameter int SW = conv_pkg::SW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          start,
    input  logic [TW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic          done,
    output logic [TW-1:0] quotient
);
    logic [TW-1:0] rem;
    logic [SW-1:0] dvs;
    logic          active;
    assign done = active && (rem < TW'(dvs));
    // subtract the divisor each enabled cycle until the remainder falls below it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            active   <= 1'b0;
        end else if (en) begin
            if (start) begin
                rem      <= dividend;
                dvs      <= divisor;
                quotient <= '0;
                active   <= 1'b1;
            end else if (done) begin
                active   <= 1'b0;
            end else if (active) begin
                rem      <= rem - TW'(dvs);
                quotient <= quotient + 1'b1;
            end
        end
    end
endmodule

// File: rtl/conv_seq_unit.sv
// conv_seq_unit: im2col read-address sequencer for a strided square convolution
module conv_seq_unit #(
    parameter int TW = conv_pkg::TW,
    parameter int KW = conv_pkg::KW,
    parameter int CW = conv_pkg::CW,
    parameter int SW = conv_pkg::SW,
    parameter int AW = conv_pkg::AW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic          start_conv,
    input  logic [TW-1:0] tensor_size,
    input  logic [KW-1:0] kernel_size,
    input  logic [CW-1:0] channels,
    input  logic [SW-1:0] stride,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_addr,
    output logic          rd_last,
    output logic          n_para_done,
    output logic [TW-1:0] n_ofs,
    output logic          w_done,
    output logic          busy,
    output logic          cfg_err
);
    import conv_pkg::*;
    state_t        state;
    logic          start_q;
    logic [TW-1:0] t_r, ox, oy, ox_n, oy_n, quotient;
    logic [KW-1:0] k_r, kx, ky, kx_n, ky_n;
    logic [CW-1:0] c_r, ch, ch_n;
    logic [SW-1:0] s_r;
    logic [AW-1:0] addr_n;
    logic          start_edge, cfg_bad, div_start, div_done;
    logic          kx_l, ky_l, ch_l, ox_l, oy_l, fin, last_n;
    assign start_edge = start_conv && !start_q;
    assign cfg_bad    = (kernel_size == '0) || (stride == '0) || (channels == '0) ||
                        (TW'(kernel_size) > tensor_size);
    assign div_start  = (state == IDLE) && start_edge && !cfg_bad;
    ofs_divider #(.TW(TW), .SW(SW)) u_div (
        .clk      (clk),
        .rstn     (rstn),
        .en       (enable),
        .start    (div_start),
        .dividend (tensor_size - TW'(kernel_size)),
        .divisor  (stride),
        .done     (div_done),
        .quotient (quotient)
    );
    // next loop-nest position (kx innermost, oy outermost) and its address
    always_comb begin
        kx_l   = kx == k_r - 1'b1;
        ky_l   = ky == k_r - 1'b1;
        ch_l   = ch == c_r - 1'b1;
        ox_l   = ox == n_ofs;
        oy_l   = oy == n_ofs;
        fin    = kx_l && ky_l && ch_l && ox_l && oy_l;
        kx_n   = kx_l ? '0 : kx + 1'b1;
        ky_n   = !kx_l ? ky : ky_l ? '0 : ky + 1'b1;
        ch_n   = !(kx_l && ky_l) ? ch : ch_l ? '0 : ch + 1'b1;
        ox_n   = !(kx_l && ky_l && ch_l) ? ox : ox_l ? '0 : ox + 1'b1;
        oy_n   = !(kx_l && ky_l && ch_l && ox_l) ? oy : oy + 1'b1;
        last_n = (ch_n == c_r - 1'b1) && (ky_n == k_r - 1'b1) && (kx_n == k_r - 1'b1);
        addr_n = (AW'(ch_n) * AW'(t_r) + AW'(oy_n) * AW'(s_r) + AW'(ky_n)) * AW'(t_r)
               + AW'(ox_n) * AW'(s_r) + AW'(kx_n);
    end
    // sequencer FSM with registered outputs; everything holds while enable is low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            t_r         <= '0;
            k_r         <= '0;
            c_r         <= '0;
            s_r         <= '0;
            ox          <= '0;
            oy          <= '0;
            kx          <= '0;
            ky          <= '0;
            ch          <= '0;
            rd_valid    <= 1'b0;
            rd_addr     <= '0;
            rd_last     <= 1'b0;
            n_para_done <= 1'b0;
            n_ofs       <= '0;
            w_done      <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
        end else if (enable) begin
            start_q     <= start_conv;
            n_para_done <= 1'b0;
            w_done      <= 1'b0;
            cfg_err     <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    t_r     <= tensor_size;
                    k_r     <= kernel_size;
                    c_r     <= channels;
                    s_r     <= stride;
                    ox      <= '0;
                    oy      <= '0;
                    kx      <= '0;
                    ky      <= '0;
                    ch      <= '0;
                    busy    <= 1'b1;
                    cfg_err <= cfg_bad;
                    state   <= cfg_bad ? DONE : CALC;
                end
                CALC: if (!start_conv) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (n_para_done) begin
                    rd_valid <= 1'b1;
                    rd_addr  <= '0;
                    rd_last  <= (c_r == CW'(1)) && (k_r == KW'(1));
                    state    <= RUN;
                end else if (div_done) begin
                    n_ofs       <= quotient;
                    n_para_done <= 1'b1;
                end
                RUN: if (!start_conv) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end else if (rd_valid && rd_ready) begin
                    if (fin) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        state    <= DONE;
                    end else begin
                        kx      <= kx_n;
                        ky      <= ky_n;
                        ch      <= ch_n;
                        ox      <= ox_n;
                        oy      <= oy_n;
                        rd_addr <= addr_n;
                        rd_last <= last_n;
                    end
                end
                DONE: begin
                    w_done <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_seq_unit.sv
// tb_conv_seq_unit: randomized check of conv_seq_unit against a loop-nest reference model
`timescale 1ns/1ps
module tb_conv_seq_unit;
    localparam int TW = 8, KW = 4, CW = 8, SW = 2, AW = 16;
    logic          clk = 1'b0, rstn = 1'b0, enable = 1'b0, start_conv = 1'b0, rd_ready = 1'b0;
    logic [TW-1:0] tensor_size = '0;
    logic [KW-1:0] kernel_size = '0;
    logic [CW-1:0] channels = '0;
    logic [SW-1:0] stride = '0;
    logic          rd_valid, rd_last, n_para_done, w_done, busy, cfg_err;
    logic [AW-1:0] rd_addr;
    logic [TW-1:0] n_ofs;
    int n_chk = 0, n_err = 0;
    int got[$];

    always #5 clk = ~clk;

    conv_seq_unit dut (
        .clk(clk), .rstn(rstn), .enable(enable), .start_conv(start_conv),
        .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels), .stride(stride),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_last(rd_last),
        .n_para_done(n_para_done), .n_ofs(n_ofs), .w_done(w_done), .busy(busy), .cfg_err(cfg_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_conv(input int t, input int k, input int c, input int s, input bit rnd);
        int ea[$];
        bit el[$];
        int q, npd, last_x, n_exp, idx, paddr;
        bit done, pstall, plast;
        q = (t - k) / s;
        for (int oy = 0; oy <= q; oy++)
            for (int ox = 0; ox <= q; ox++)
                for (int ci = 0; ci < c; ci++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            ea.push_back(((ci * t + oy * s + ky) * t + ox * s + kx) & 32'hFFFF);
                            el.push_back(ci == c - 1 && ky == k - 1 && kx == k - 1);
                        end
        n_exp = ea.size();
        got.delete();
        npd = 0; last_x = -1; done = 0; pstall = 0; paddr = 0; plast = 0;
        @(negedge clk);
        tensor_size = TW'(t); kernel_size = KW'(k); channels = CW'(c); stride = SW'(s);
        start_conv = 1'b1; enable = 1'b1; rd_ready = 1'b1;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            if (rnd) begin
                rd_ready = ($urandom_range(0, 3) != 0);
                enable   = ($urandom_range(0, 7) != 0);
            end
            #1;
            if (pstall) begin
                check("hold_valid", rd_valid, 1);
                check("hold_addr", rd_addr, paddr);
                check("hold_last", rd_last, plast);
            end
            pstall = rd_valid && !(rd_ready && enable);
            paddr = rd_addr;
            plast = rd_last;
            if (enable && n_para_done) begin
                npd++;
                check("n_ofs", n_ofs, q);
            end
            if (enable && rd_valid && rd_ready) begin
                idx = got.size();
                got.push_back(rd_addr);
                if (idx < n_exp) begin
                    check("rd_addr", rd_addr, ea[idx]);
                    check("rd_last", rd_last, el[idx]);
                end else check("xfer_overrun", idx + 1, n_exp);
                if (idx == n_exp - 1) last_x = cyc;
            end
            if (!rnd && last_x >= 0 && cyc == last_x + 1) check("valid_after_last", rd_valid, 0);
            if (enable && w_done) begin
                done = 1;
                if (!rnd) check("w_done_lat", cyc - last_x, 2);
                check("busy_at_w_done", busy, 0);
            end
        end
        check("run_done", done, 1);
        check("xfers", got.size(), n_exp);
        check("n_para_done_cnt", npd, 1);
        @(negedge clk);
        start_conv = 1'b0; enable = 1'b1; rd_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int e28[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int bad_cfg[4][4] = '{'{5, 6, 1, 1}, '{5, 0, 1, 1}, '{5, 3, 0, 1}, '{5, 3, 1, 0}};
        int err_cyc, wd_cyc, bad;
        int t, k;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_n_ofs", n_ofs, 0);
        @(negedge clk);
        rstn = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clk);

        run_conv(5, 3, 1, 1, 0);
        for (int i = 0; i < 9; i++) check("t5_first9", got[i], e28[i]);
        run_conv(7, 3, 2, 2, 0);
        check("t7_total", got.size(), 162);
        check("t7_addr10", got[9], 49);
        check("t7_patch01", got[18], 2);
        run_conv(4, 4, 1, 3, 0);
        check("t4_total", got.size(), 16);
        check("t4_last_addr", got[15], 15);

        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            tensor_size = TW'(bad_cfg[b][0]); kernel_size = KW'(bad_cfg[b][1]);
            channels = CW'(bad_cfg[b][2]); stride = SW'(bad_cfg[b][3]);
            start_conv = 1'b1;
            err_cyc = -1; wd_cyc = -1; bad = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                #1;
                if (cfg_err && err_cyc < 0) err_cyc = i;
                if (w_done && wd_cyc < 0) wd_cyc = i;
                if (rd_valid || n_para_done) bad++;
            end
            check("cfg_err_cyc", err_cyc, 0);
            check("cfg_w_done_cyc", wd_cyc, 1);
            check("cfg_no_read", bad, 0);
            start_conv = 1'b0;
            repeat (2) @(negedge clk);
        end

        for (int r = 0; r < 8; r++) begin
            t = $urandom_range(1, 10);
            k = $urandom_range(1, t);
            run_conv(t, k, $urandom_range(1, 3), $urandom_range(1, 3), 1);
        end

        @(negedge clk);
        tensor_size = 8'd5; kernel_size = 4'd3; channels = 8'd1; stride = 2'd1;
        start_conv = 1'b1; rd_ready = 1'b1; enable = 1'b1;
        repeat (30) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("midrst_valid", rd_valid, 0);
        check("midrst_addr", rd_addr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_n_ofs", n_ofs, 0);
        @(negedge clk);
        rstn = 1'b1; start_conv = 1'b0;
        repeat (2) @(negedge clk);
        run_conv(5, 3, 1, 1, 0);
        check("rerun_first", got[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/conv_seq_unit.md
CONV_SEQ_UNIT -- requirements
Module: conv_seq_unit

Interface
REQ-001 SHALL have parameter TW, default 8: tensor size width.
REQ-002 SHALL have parameter KW, default 4: kernel size width.
REQ-003 SHALL have parameter CW, default 8: channel count width.
REQ-004 SHALL have parameter SW, default 2: stride width.
REQ-005 SHALL have parameter AW, default 16: read address width.
REQ-006 SHALL have ports, one per line:
- clk, in, 1: clock.
- rstn, in, 1: reset, asynchronous, active-low.
- enable, in, 1: global advance; when low, all state is frozen.
- start_conv, in, 1: level request from the convolution controller; held high until after w_done.
- tensor_size, in, TW: input tensor edge length T.
- kernel_size, in, KW: kernel edge length K.
- channels, in, CW: input channel count C.
- stride, in, SW: stride S.
- rd_valid, out, 1: read address valid.
- rd_ready, in, 1: downstream accepts the address.
- rd_addr, out, AW: feature-buffer read address.
- rd_last, out, 1: marks the final element of one im2col patch.
- n_para_done, out, 1: one-cycle pulse; n_ofs is valid.
- n_ofs, out, TW: last output index, floor((T-K)/S).
- w_done, out, 1: one-cycle pulse; the convolution sequence is finished.
- busy, out, 1: high in any state other than IDLE.
- cfg_err, out, 1: one-cycle pulse on an illegal configuration.

Function
REQ-007 SHALL implement the one-hot FSM IDLE, CALC, RUN, DONE.
REQ-008 SHALL detect a start as a rising edge of start_conv, using a registered copy of start_conv, and SHALL act on it only in IDLE.
REQ-009 SHALL capture T, K, C and S in the start-edge cycle and hold them until the next return to IDLE.
REQ-010 SHALL go IDLE->DONE with a cfg_err pulse, no rd_valid and no n_para_done when K=0, S=0, C=0 or K>T; otherwise it SHALL go IDLE->CALC.
REQ-011 In CALC, SHALL compute Q=floor((T-K)/S) by repeated subtraction, one subtraction per enabled cycle, taking Q+1 cycles.
REQ-012 When the CALC loop ends, SHALL drive n_ofs=Q, pulse n_para_done for one cycle, enter RUN on the next cycle, and hold n_ofs until the next start.
REQ-013 In RUN, SHALL issue addresses in loop order oy (outer), ox, c, ky, kx (inner), with oy and ox running 0..Q, c running 0..C-1, and ky and kx running 0..K-1.
REQ-014 SHALL compute rd_addr = (c*T + oy*S + ky)*T + ox*S + kx, truncated to AW bits.
REQ-015 Handshake: a transfer occurs when rd_valid and rd_ready are both high; while rd_valid is high and rd_ready is low, rd_addr and rd_last SHALL hold stable.
REQ-016 rd_valid SHALL NOT drop without a transfer, except on abort (REQ-020) or reset.
REQ-017 SHALL assert rd_last with the address where c=C-1, ky=K-1 and kx=K-1.
REQ-018 On the transfer of the final address (oy=ox=Q plus the rd_last condition), SHALL go RUN->DONE with rd_valid low in the following cycle.
REQ-019 In DONE, SHALL pulse w_done for one cycle, then go DONE->IDLE.
REQ-020 If start_conv goes low during CALC or RUN, SHALL return to IDLE next cycle with rd_valid low and no w_done.
REQ-021 With enable low, SHALL freeze all outputs and counters, and SHALL not lose pulses, which are delayed until enable returns high.
REQ-022 SHALL sustain one transfer per cycle when rd_ready is held high.

Reset
REQ-023 On rstn low, asynchronously: FSM to IDLE; rd_valid, rd_last, n_para_done, w_done, busy and cfg_err to 0; rd_addr and n_ofs to 0; captured configuration and counters to 0.
REQ-024 A reset mid-operation SHALL abandon the sequence; the first rising edge of start_conv after rstn release starts a fresh run.

Structure
REQ-025 A shared package conv_pkg SHALL hold the state encodings and the default width constants TW, KW, CW, SW and AW.
REQ-026 The divider SHALL be a sub-module ofs_divider with start/done handshake, dividend T-K, divisor S, and quotient output.
REQ-027 Patch counters and address arithmetic SHALL stay in conv_seq_unit.

Verification
REQ-028 T=5, K=3, S=1, C=1, rd_ready=1: n_ofs=2 and n_para_done once; 81 transfers; the first nine addresses are 0,1,2,5,6,7,10,11,12; rd_last on every 9th transfer; w_done one cycle after the last transfer.
REQ-029 T=7, K=3, S=2, C=2: n_ofs=2; 18 transfers per patch; the 10th address is 49; the first address of patch (oy=0, ox=1) is 2; 162 transfers in total.
REQ-030 T=4, K=4, S=3, C=1: n_ofs=0; a single 16-address patch (0..3, 4..7, 8..11, 12..15); rd_last on address 15.
REQ-031 Hold rd_ready low for 5 cycles mid-patch: rd_addr and rd_last stay constant, rd_valid stays high, and no address is skipped or repeated.
REQ-032 K=6, T=5: cfg_err pulse, then w_done pulse; rd_valid and n_para_done never assert.
REQ-033 Drop enable for 4 cycles in RUN: the sequence freezes and resumes unchanged. Drop rstn mid-RUN: all outputs are 0 immediately, and a new start edge reruns from address 0.
